// File: rtl/myproject_div_pkg.sv
// rtl/myproject_div_pkg.sv - shared types and constants for the sequential divider
package myproject_div_pkg;

  localparam int DIN0_W = 11;
  localparam int DIN1_W = 3;
  localparam int DOUT_W = 8;
  localparam int REM_W  = 4;

  // Bit counter only has to reach din0 width - 1
  localparam int CNT_W = $clog2(DIN0_W);

  localparam int DIV_QMAX = 127;
  localparam int DIV_QMIN = -128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/myproject_div_if.sv
// rtl/myproject_div_if.sv - operand/result handshake bundle for the divider
// master: operand producer and result consumer
// slave : the divider
import myproject_div_pkg::*;

interface myproject_div_if #(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W,
  parameter int rem_WIDTH  = REM_W
);

  logic                          din_valid;
  logic                          din_ready;
  logic signed [din0_WIDTH-1:0]  din0;
  logic        [din1_WIDTH-1:0]  din1;
  logic                          dout_valid;
  logic                          dout_ready;
  logic signed [dout_WIDTH-1:0]  dout;
  logic signed [rem_WIDTH-1:0]   rem;
  logic                          ovf;
  logic                          dbz;

  modport master (
    output din_valid, din0, din1, dout_ready,
    input  din_ready, dout_valid, dout, rem, ovf, dbz
  );

  modport slave (
    input  din_valid, din0, din1, dout_ready,
    output din_ready, dout_valid, dout, rem, ovf, dbz
  );

endinterface

// File: rtl/myproject_div_step.sv
// rtl/myproject_div_step.sv - one combinational restoring-division step
// prem     : partial remainder in (always < divisor)
// dbit     : next dividend magnitude bit, MSB first
// divisor  : unsigned divisor
// prem_nxt : partial remainder out
// qbit     : quotient bit produced by this step
module myproject_div_step #(
  parameter int W = 3
) (
  input  logic [W-1:0] prem,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] prem_nxt,
  output logic         qbit
);

  logic [W:0] trial;

  assign trial = {prem, dbit};
  assign qbit  = (trial >= {1'b0, divisor});

  // Result is below divisor in both branches, so the top bit is always zero
  assign prem_nxt = qbit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];

endmodule

// File: rtl/myproject_div_11s_3ns_8_seq.sv
// rtl/myproject_div_11s_3ns_8_seq.sv - sequential signed/unsigned divider, saturating quotient
// ap_clk : clock, rising edge
// ap_rst : synchronous active-high reset, aborts any operation in flight
// bus    : din_valid/din_ready/din0/din1 operand side,
//          dout_valid/dout_ready/dout/rem/ovf/dbz result side
import myproject_div_pkg::*;

module myproject_div_11s_3ns_8_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W,
  parameter int rem_WIDTH  = REM_W
) (
  input  logic           ap_clk,
  input  logic           ap_rst,
  myproject_div_if.slave bus
);

  // One extra bit so that |-1024| = 1024 survives re-signing
  localparam int MAG_W = din0_WIDTH + 1;

  localparam logic signed [MAG_W-1:0]    QMAX_M = MAG_W'(DIV_QMAX);
  localparam logic signed [MAG_W-1:0]    QMIN_M = MAG_W'(DIV_QMIN);
  localparam logic signed [dout_WIDTH-1:0] QMAX_O = dout_WIDTH'(DIV_QMAX);
  localparam logic signed [dout_WIDTH-1:0] QMIN_O = dout_WIDTH'(DIV_QMIN);

  state_t                  state;
  logic                    sign;
  logic [din0_WIDTH-1:0]   qsh;      // dividend bits shift out the top, quotient bits in the bottom
  logic [din1_WIDTH-1:0]   prem;
  logic [din1_WIDTH-1:0]   divisor;
  logic [CNT_W-1:0]        cnt;

  logic [din0_WIDTH-1:0]   din0_u;
  logic [din0_WIDTH-1:0]   din0_mag;
  logic [din1_WIDTH-1:0]   prem_nxt;
  logic                    qbit;
  logic [MAG_W-1:0]        qmag;
  logic signed [MAG_W-1:0] q_s;
  logic [rem_WIDTH-1:0]    rmag;
  logic [rem_WIDTH-1:0]    r_s;
  logic [dout_WIDTH-1:0]   q_sat;
  logic                    q_ovf;

  assign din0_u   = bus.din0;
  assign din0_mag = din0_u[din0_WIDTH-1] ? (~din0_u + din0_WIDTH'(1)) : din0_u;

  myproject_div_step #(.W(din1_WIDTH)) u_step (
    .prem     (prem),
    .dbit     (qsh[din0_WIDTH-1]),
    .divisor  (divisor),
    .prem_nxt (prem_nxt),
    .qbit     (qbit)
  );

  // Final-step view of the result, only consumed on the last CALC cycle
  assign qmag = {1'b0, qsh[din0_WIDTH-2:0], qbit};
  assign q_s  = sign ? -$signed(qmag) : $signed(qmag);
  assign rmag = {1'b0, prem_nxt};
  assign r_s  = sign ? -rmag : rmag;

  always_comb begin
    q_sat = q_s[dout_WIDTH-1:0];
    q_ovf = 1'b0;
    if (q_s > QMAX_M) begin
      q_sat = QMAX_O;
      q_ovf = 1'b1;
    end else if (q_s < QMIN_M) begin
      q_sat = QMIN_O;
      q_ovf = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state          <= IDLE;
      bus.din_ready  <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.rem        <= '0;
      bus.ovf        <= 1'b0;
      bus.dbz        <= 1'b0;
      sign           <= 1'b0;
      qsh            <= '0;
      prem           <= '0;
      divisor        <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.din_ready <= 1'b1;
          if (bus.din_valid && bus.din_ready) begin
            bus.din_ready <= 1'b0;
            sign          <= din0_u[din0_WIDTH-1];
            qsh           <= din0_mag;
            prem          <= '0;
            divisor       <= bus.din1;
            cnt           <= CNT_W'(din0_WIDTH - 1);
            if (bus.din1 == '0) begin
              // Divide by zero skips CALC and saturates toward the dividend's sign
              state          <= DONE;
              bus.dout_valid <= 1'b1;
              bus.dout       <= din0_u[din0_WIDTH-1] ? QMIN_O : QMAX_O;
              bus.rem        <= '0;
              bus.ovf        <= 1'b0;
              bus.dbz        <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          qsh  <= {qsh[din0_WIDTH-2:0], qbit};
          prem <= prem_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state          <= DONE;
            bus.dout_valid <= 1'b1;
            bus.dout       <= q_sat;
            bus.rem        <= r_s;
            bus.ovf        <= q_ovf;
            bus.dbz        <= 1'b0;
          end
        end

        DONE: begin
          if (bus.dout_ready) begin
            state          <= IDLE;
            bus.dout_valid <= 1'b0;
            bus.din_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_div_11s_3ns_8_seq.sv
// tb/tb_myproject_div_11s_3ns_8_seq.sv - self-checking bench for the sequential divider
module tb_myproject_div_11s_3ns_8_seq;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  myproject_div_if bus ();

  myproject_div_11s_3ns_8_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    logic signed [10:0] a;
    logic        [2:0]  b;
    logic signed [7:0]  q;
    logic signed [3:0]  r;
    logic               ovf;
    logic               dbz;
  } vec_t;

  typedef struct {
    logic signed [7:0] q;
    logic signed [3:0] r;
    logic              ovf;
    logic              dbz;
    int                lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void add(input int a, input int b, input int q, input int r,
                              input int o, input int z);
    vec_t v;
    v.a = 11'(a);
    v.b = 3'(b);
    v.q = 8'(q);
    v.r = 4'(r);
    v.ovf = o[0];
    v.dbz = z[0];
    tbl.push_back(v);
  endfunction

  // Reference model using SV integer division (truncates toward zero like C)
  function automatic exp_t model(input logic signed [10:0] a, input logic [2:0] b);
    exp_t e;
    int   qi;
    int   ri;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.lat = 12;
    if (b == 3'd0) begin
      e.q   = (a < 0) ? 8'h80 : 8'h7f;
      e.r   = 4'd0;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      qi  = int'(a) / int'({1'b0, b});
      ri  = int'(a) % int'({1'b0, b});
      e.r = ri[3:0];
      if (qi > 127) begin
        e.q = 8'h7f;
        e.ovf = 1'b1;
      end else if (qi < -128) begin
        e.q = 8'h80;
        e.ovf = 1'b1;
      end else begin
        e.q = qi[7:0];
      end
    end
    return e;
  endfunction

  task automatic run_op(input logic signed [10:0] a, input logic [2:0] b,
                        input exp_t e, input int hold);
    int   n;
    int   lat;
    exp_t got;
    @(negedge ap_clk);
    n = 0;
    while (!bus.din_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!bus.din_ready) begin
      check("din_ready_timeout", 0, 1);
      return;
    end
    bus.din_valid = 1'b1;
    bus.din0      = a;
    bus.din1      = b;
    sb.push_back(e);
    @(posedge ap_clk);
    #1;
    // Operands now change under an active din_valid; the DUT must ignore them
    bus.din0 = 11'($urandom);
    bus.din1 = 3'($urandom);
    check("din_ready_busy", int'(bus.din_ready), 0);
    lat = 1;
    while (!bus.dout_valid && lat < 40) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    bus.din_valid = 1'b0;
    got = sb.pop_front();
    if (!bus.dout_valid) begin
      check("dout_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, got.lat);
    check("dout", int'($signed(bus.dout)), int'(got.q));
    check("rem", int'($signed(bus.rem)), int'(got.r));
    check("ovf", int'(bus.ovf), int'(got.ovf));
    check("dbz", int'(bus.dbz), int'(got.dbz));
    for (int i = 0; i < hold; i++) begin
      bus.din_valid = 1'b1;
      bus.din0      = 11'($urandom);
      bus.din1      = 3'($urandom);
      @(posedge ap_clk);
      #1;
      check("hold_valid", int'(bus.dout_valid), 1);
      check("hold_dout", int'($signed(bus.dout)), int'(got.q));
      check("hold_rem", int'($signed(bus.rem)), int'(got.r));
      check("hold_din_ready", int'(bus.din_ready), 0);
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.dout_ready = 1'b0;
    check("valid_drop", int'(bus.dout_valid), 0);
    check("ready_return", int'(bus.din_ready), 1);
  endtask

  initial begin
    exp_t e;
    int   n;
    logic seen;
    logic signed [10:0] ra;
    logic [2:0] rb;

    bus.din_valid  = 1'b0;
    bus.din0       = '0;
    bus.din1       = '0;
    bus.dout_ready = 1'b0;
    ap_rst         = 1'b1;

    add(100, 5, 20, 0, 0, 0);
    add(-100, 7, -14, -2, 0, 0);
    add(100, 7, 14, 2, 0, 0);
    add(1023, 1, 127, 0, 1, 0);
    add(-1024, 1, -128, 0, 1, 0);
    add(-128, 1, -128, 0, 0, 0);
    add(17, 0, 127, 0, 0, 1);
    add(-5, 0, -128, 0, 0, 1);
    add(255, 2, 127, 1, 0, 0);
    add(896, 7, 127, 0, 1, 0);
    add(-896, 7, -128, 0, 0, 0);
    add(-1024, 7, -128, -2, 1, 0);
    add(1023, 6, 127, 3, 1, 0);
    add(-1, 7, 0, -1, 0, 0);
    add(0, 3, 0, 0, 0, 0);
    add(-7, 7, -1, 0, 0, 0);

    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_din_ready", int'(bus.din_ready), 0);
    check("rst_dout_valid", int'(bus.dout_valid), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_rem", int'(bus.rem), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_dbz", int'(bus.dbz), 0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("post_rst_din_ready", int'(bus.din_ready), 1);

    foreach (tbl[i]) begin
      e.q   = tbl[i].q;
      e.r   = tbl[i].r;
      e.ovf = tbl[i].ovf;
      e.dbz = tbl[i].dbz;
      e.lat = (tbl[i].b == 3'd0) ? 1 : 12;
      run_op(tbl[i].a, tbl[i].b, e, (i == 0) ? 5 : 0);
    end

    for (int i = 0; i < 10; i++) begin
      ra = 11'($urandom);
      rb = 3'($urandom);
      run_op(ra, rb, model(ra, rb), 0);
    end

    // Reset during CALC: the aborted op must never produce a result
    @(negedge ap_clk);
    n = 0;
    while (!bus.din_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    bus.din_valid = 1'b1;
    bus.din0      = 11'sd50;
    bus.din1      = 3'd3;
    @(posedge ap_clk);
    #1;
    bus.din_valid = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("abort_din_ready", int'(bus.din_ready), 0);
    check("abort_dout_valid", int'(bus.dout_valid), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk);
      #1;
      if (bus.dout_valid) seen = 1'b1;
    end
    check("abort_no_result", int'(seen), 0);
    run_op(11'sd9, 3'd3, model(11'sd9, 3'd3), 0);

    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
